// File: rtl/tl_pkg.sv
// Shared definitions for the intersection_ctrl traffic-light controller:
// FSM state encoding, lamp colour constants and per-channel rgb field width.
package tl_pkg;

    localparam int unsigned RGB_W = 3;

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_REDYEL = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FLASH  = 3'd4
    } tl_state_e;

    localparam logic [RGB_W-1:0] LAMP_RED    = 3'b100;
    localparam logic [RGB_W-1:0] LAMP_REDYEL = 3'b110;
    localparam logic [RGB_W-1:0] LAMP_GREEN  = 3'b010;
    localparam logic [RGB_W-1:0] LAMP_YELLOW = 3'b110;
    localparam logic [RGB_W-1:0] LAMP_OFF    = 3'b000;

endpackage

// File: rtl/tl_tick_gen.sv
// Tick prescaler: one-cycle tick every DIV clocks; clr restarts the count so
// a freshly entered phase always gets full-length ticks.
module tl_tick_gen #(
    parameter int unsigned DIV = 12000000
) (
    input  logic clk,
    input  logic resn,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    // Tick on the last count of the period; restart on tick or clear
    always_comb begin
        tick  = (cnt_q == CW'(DIV - 1));
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Demand-driven traffic-light controller for NUM_CH approaches, serving one
// channel at a time in round-robin order.
// Optional night flash mode is compiled in with macro TL_NIGHT_FLASH_EN.
module intersection_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned TICK_DIV = 12000000,
    parameter int unsigned ALLRED_T = 2,
    parameter int unsigned REDYEL_T = 1,
    parameter int unsigned GREEN_T  = 8,
    parameter int unsigned YELLOW_T = 2
) (
    input  logic                        clk,
    input  logic                        resn,
    input  logic [NUM_CH-1:0]           btn,
    input  logic                        night,
    output logic [RGB_W*NUM_CH-1:0]     rgb,
    output logic [$clog2(NUM_CH)-1:0]   active_ch,
    output logic [2:0]                  phase
);

    localparam int unsigned AW     = $clog2(NUM_CH);
    localparam int unsigned MAX_AR = (ALLRED_T > REDYEL_T) ? ALLRED_T : REDYEL_T;
    localparam int unsigned MAX_GY = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int unsigned MAXD   = (MAX_AR > MAX_GY) ? MAX_AR : MAX_GY;
    localparam int unsigned PW     = (MAXD > 1) ? $clog2(MAXD) : 1;

    // Parameter legality
    if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num_ch
        $error("intersection_ctrl: NUM_CH must be 2..8");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("intersection_ctrl: TICK_DIV must be >= 2");
    end
    if (ALLRED_T < 1 || REDYEL_T < 1 || GREEN_T < 1 || YELLOW_T < 1) begin : g_bad_dur
        $error("intersection_ctrl: phase durations must be >= 1");
    end

    tl_state_e          state_q, state_d;
    logic [AW-1:0]      act_q, act_d;
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [PW-1:0]      ph_cnt_q, ph_cnt_d;
    logic [PW-1:0]      dur_m1;
    logic               tick;
    logic               clr;
    logic               expired;
    logic [NUM_CH-1:0]  btn_eff;
    logic [NUM_CH-1:0]  req;
    logic [NUM_CH-1:0]  req_other;
    logic               any_req;
    logic [AW-1:0]      rr_pick;
    logic [AW-1:0]      rr_idx;
    logic               rr_found;
    int unsigned        rr_sum;
    logic [RGB_W-1:0]   lamp_act;

`ifdef TL_NIGHT_FLASH_EN
    logic               flash_q, flash_d;
`else
    logic               unused_night;
    assign unused_night = night;
`endif

    tl_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .resn (resn),
        .clr  (clr),
        .tick (tick)
    );

    // Demand seen this cycle: latched requests plus live buttons, except the
    // channel already showing green
    always_comb begin
        btn_eff = btn;
        if (state_q == ST_GREEN) begin
            btn_eff[act_q] = 1'b0;
        end
        req          = pend_q | btn_eff;
        req_other    = req;
        req_other[act_q] = 1'b0;
        any_req      = |req;
    end

    // Round-robin pick: first requester after the active channel, wrapping
    // back to the active channel itself last
    always_comb begin
        rr_pick  = act_q;
        rr_found = 1'b0;
        rr_sum   = 0;
        rr_idx   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            rr_sum = (int'(act_q) + i) % NUM_CH;
            rr_idx = AW'(rr_sum);
            if (!rr_found && req[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Duration (minus one) of the current phase and tick-aligned expiry
    always_comb begin
        case (state_q)
            ST_ALLRED: dur_m1 = PW'(ALLRED_T - 1);
            ST_REDYEL: dur_m1 = PW'(REDYEL_T - 1);
            ST_GREEN:  dur_m1 = PW'(GREEN_T - 1);
            ST_YELLOW: dur_m1 = PW'(YELLOW_T - 1);
            default:   dur_m1 = '0;
        endcase
        expired = tick && (ph_cnt_q >= dur_m1);
    end

    // Phase sequencing, channel selection and pending bookkeeping
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = req;
        case (state_q)
            ST_ALLRED: begin
                if (expired) begin
`ifdef TL_NIGHT_FLASH_EN
                    if (night) begin
                        state_d = ST_FLASH;
                    end else
`endif
                    if (any_req) begin
                        state_d = ST_REDYEL;
                        act_d   = rr_pick;
                    end
                end
            end
            ST_REDYEL: begin
                if (expired) begin
                    state_d       = ST_GREEN;
                    pend_d[act_q] = 1'b0;
                end
            end
            ST_GREEN: begin
                if (expired && (|req_other)) begin
                    state_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (expired) begin
                    state_d = ST_ALLRED;
                end
            end
`ifdef TL_NIGHT_FLASH_EN
            ST_FLASH: begin
                if (tick && !night) begin
                    state_d = ST_ALLRED;
                end
            end
`endif
            default: begin
                state_d = ST_ALLRED;
            end
        endcase
    end

    // Phase tick counter: restarts on every state change, saturates so an
    // extended phase keeps re-evaluating on each tick
    always_comb begin
        clr      = (state_d != state_q);
        ph_cnt_d = ph_cnt_q;
        if (clr) begin
            ph_cnt_d = '0;
        end else if (tick && (ph_cnt_q != PW'(MAXD - 1))) begin
            ph_cnt_d = ph_cnt_q + 1'b1;
        end
    end

`ifdef TL_NIGHT_FLASH_EN
    // Flash lamp phase: yellow on entry, toggles every tick
    always_comb begin
        flash_d = flash_q;
        if (state_q != ST_FLASH && state_d == ST_FLASH) begin
            flash_d = 1'b1;
        end else if (state_q == ST_FLASH && tick) begin
            flash_d = ~flash_q;
        end
    end
`endif

    // Controller state registers
    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q  <= ST_ALLRED;
            act_q    <= AW'(NUM_CH - 1);
            pend_q   <= '0;
            ph_cnt_q <= '0;
`ifdef TL_NIGHT_FLASH_EN
            flash_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            ph_cnt_q <= ph_cnt_d;
`ifdef TL_NIGHT_FLASH_EN
            flash_q  <= flash_d;
`endif
        end
    end

    // Lamp shown on the active channel for the current phase
    always_comb begin
        case (state_q)
            ST_REDYEL: lamp_act = LAMP_REDYEL;
            ST_GREEN:  lamp_act = LAMP_GREEN;
            ST_YELLOW: lamp_act = LAMP_YELLOW;
            default:   lamp_act = LAMP_RED;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lamp
`ifdef TL_NIGHT_FLASH_EN
        assign rgb[RGB_W*g +: RGB_W] = (state_q == ST_FLASH)
                                     ? (flash_q ? LAMP_YELLOW : LAMP_OFF)
                                     : ((act_q == AW'(g)) ? lamp_act : LAMP_RED);
`else
        assign rgb[RGB_W*g +: RGB_W] = (act_q == AW'(g)) ? lamp_act : LAMP_RED;
`endif
    end

    assign active_ch = act_q;
    assign phase     = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Bench for intersection_ctrl: directed scenarios plus randomized demand,
// night and reset, checked every cycle against a cycle-count timeline model.
module tb_intersection_ctrl;
    import tl_pkg::*;

    localparam int NC = 2;
    localparam int TD = 4;
    localparam int AR = 2;
    localparam int RY = 1;
    localparam int GT = 5;
    localparam int YT = 2;
`ifdef TL_NIGHT_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    // model phase names
    localparam int P_ALLRED = 0;
    localparam int P_REDYEL = 1;
    localparam int P_GREEN  = 2;
    localparam int P_YELLOW = 3;
    localparam int P_FLASH  = 4;

    logic            clk = 1'b0;
    logic            resn = 1'b0;
    logic [NC-1:0]   btn = '0;
    logic            night = 1'b0;
    logic [3*NC-1:0] rgb;
    logic [0:0]      active_ch;
    logic [2:0]      phase;

    int unsigned total = 0;
    int unsigned bad = 0;

    // reference model state
    int          m_ph;
    int          m_act;
    logic [NC-1:0] m_pend;
    int          m_cyc;

    intersection_ctrl #(
        .NUM_CH   (NC),
        .TICK_DIV (TD),
        .ALLRED_T (AR),
        .REDYEL_T (RY),
        .GREEN_T  (GT),
        .YELLOW_T (YT)
    ) dut (
        .clk       (clk),
        .resn      (resn),
        .btn       (btn),
        .night     (night),
        .rgb       (rgb),
        .active_ch (active_ch),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3*NC-1:0] exp_rgb();
        logic [3*NC-1:0] e;
        logic [2:0] col;
        e = '0;
        for (int c = 0; c < NC; c++) begin
            if (m_ph == P_FLASH) begin
                col = (((m_cyc / TD) % 2) == 0) ? 3'b110 : 3'b000;
            end else if (c != m_act) begin
                col = 3'b100;
            end else begin
                case (m_ph)
                    P_REDYEL: col = 3'b110;
                    P_GREEN:  col = 3'b010;
                    P_YELLOW: col = 3'b110;
                    default:  col = 3'b100;
                endcase
            end
            e[3*c +: 3] = col;
        end
        return e;
    endfunction

    function automatic logic [2:0] exp_phase();
        case (m_ph)
            P_REDYEL: return ST_REDYEL;
            P_GREEN:  return ST_GREEN;
            P_YELLOW: return ST_YELLOW;
            P_FLASH:  return ST_FLASH;
            default:  return ST_ALLRED;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = P_ALLRED;
        m_act  = NC - 1;
        m_pend = '0;
        m_cyc  = 0;
    endtask

    // One rising edge: phase boundaries fall on whole ticks counted from entry
    task automatic model_step(input logic [NC-1:0] b, input logic n);
        int k, nt, nxt, c;
        bit tk;
        logic [NC-1:0] req;
        k   = m_cyc + 1;
        tk  = (k % TD) == 0;
        nt  = k / TD;
        nxt = m_ph;
        req = m_pend | b;
        if (m_ph == P_GREEN) req[m_act] = 1'b0;
        case (m_ph)
            P_ALLRED: if (tk && nt >= AR) begin
                if (FLASH_EN && n) begin
                    nxt = P_FLASH;
                end else begin
                    for (int i = 1; i <= NC; i++) begin
                        c = (m_act + i) % NC;
                        if (req[c]) begin
                            m_act = c;
                            nxt = P_REDYEL;
                            break;
                        end
                    end
                end
            end
            P_REDYEL: if (tk && nt >= RY) begin
                nxt = P_GREEN;
                req[m_act] = 1'b0;
            end
            P_GREEN:  if (tk && nt >= GT && req != '0) nxt = P_YELLOW;
            P_YELLOW: if (tk && nt >= YT) nxt = P_ALLRED;
            P_FLASH:  if (tk && !n) nxt = P_ALLRED;
            default:  nxt = P_ALLRED;
        endcase
        m_pend = req;
        m_cyc  = (nxt != m_ph) ? 0 : k;
        m_ph   = nxt;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rgb"}, 32'(rgb), 32'(exp_rgb()));
        check({tag, ".active_ch"}, 32'(active_ch), 32'(m_act));
        check({tag, ".phase"}, 32'(phase), 32'(exp_phase()));
    endtask

    // Starts and ends at a falling edge
    task automatic cyc(input logic [NC-1:0] b, input logic n, input string tag);
        btn   = b;
        night = n;
        @(posedge clk);
        model_step(b, n);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Asynchronous reset mid low-phase, released on a falling edge with btn=b
    task automatic apply_reset(input logic [NC-1:0] b);
        btn = '0;
        #2;
        resn = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        btn  = b;
        resn = 1'b1;
    endtask

    initial begin
        bit found;
        logic [NC-1:0] rb;
        logic rn;
        model_reset();
        @(negedge clk);
        #1;
        check_outputs("por");
        check("por.rgb_lit", 32'(rgb), 32'h24);
        check("por.active_lit", 32'(active_ch), 32'd1);
        apply_reset('0);

        // idle: all red forever
        for (int i = 0; i < 40; i++) cyc('0, 1'b0, "idle");
        check("idle.rgb_lit", 32'(rgb), 32'h24);

        // single demand on ch0: red+yellow from edge 8, green from edge 12
        apply_reset('0);
        for (int i = 1; i <= 60; i++) begin
            cyc((i == 1) ? 2'b01 : 2'b00, 1'b0, "ch0");
            if (i == 7)  check("ch0.before_ry", 32'(rgb), 32'h24);
            if (i == 8)  check("ch0.redyel", 32'(rgb), 32'h26);
            if (i == 11) check("ch0.redyel_end", 32'(rgb), 32'h26);
            if (i == 12) check("ch0.green", 32'(rgb), 32'h22);
            if (i == 60) check("ch0.green_held", 32'(rgb), 32'h22);
        end

        // ch1 demand while ch0 extended in green
        for (int i = 1; i <= 60; i++) cyc((i == 1) ? 2'b10 : 2'b00, 1'b0, "ch1_req");
        check("ch1_req.active_lit", 32'(active_ch), 32'd1);

        // both demanding at release: ch0 then ch1
        apply_reset(2'b11);
        for (int i = 0; i < 120; i++) begin
            cyc((i == 0) ? 2'b11 : 2'b00, 1'b0, "both");
            if (rgb[2:0] != 3'b100 && rgb[5:3] != 3'b100)
                check("both.two_nonred", 32'(rgb), 32'h24);
        end

        // reset during ch1 green
        apply_reset('0);
        cyc(2'b10, 1'b0, "to_ch1");
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc('0, 1'b0, "to_ch1");
            if (m_ph == P_GREEN && m_act == 1) found = 1'b1;
        end
        check("to_ch1.reached", 32'(found), 32'd1);
        cyc('0, 1'b0, "ch1_green");
        apply_reset('0);
        check("ch1_rst.rgb_lit", 32'(rgb), 32'h24);
        check("ch1_rst.active_lit", 32'(active_ch), 32'd1);
        for (int i = 0; i < 30; i++) cyc('0, 1'b0, "ch1_rst_idle");

`ifdef TL_NIGHT_FLASH_EN
        // night flash and recovery
        apply_reset('0);
        for (int i = 1; i <= 40; i++) begin
            cyc('0, 1'b1, "flash");
            if (i == 8)  check("flash.first_on", 32'(rgb), 32'h36);
            if (i == 12) check("flash.first_off", 32'(rgb), 32'h00);
        end
        for (int i = 0; i < 20; i++) cyc('0, 1'b0, "flash_exit");
`endif

        // randomized demand, night and reset
        rn = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            for (int c = 0; c < NC; c++) rb[c] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 149) == 0) rn = ~rn;
            if ($urandom_range(0, 799) == 0) begin
                apply_reset(rb);
            end
            cyc(rb, rn, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
